// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_sequencer_pkg;

  localparam int MULT_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_sequencer_if.sv
// Decode-stage <-> multiplier bus: request, HI/LO read hazards and product registers.
interface mult_sequencer_if
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) ();

  logic             start_mult;
  logic             mult_sign;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mfhi_d;
  logic             mflo_d;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall_d;

  modport master (
    output start_mult, mult_sign, op_a, op_b, mfhi_d, mflo_d,
    input  hi, lo, busy, done, stall_d
  );

  modport slave (
    input  start_mult, mult_sign, op_a, op_b, mfhi_d, mflo_d,
    output hi, lo, busy, done, stall_d
  );

endinterface

// File: rtl/mult_abs_neg.sv
// Conditional two's-complement negate: magnitude extraction and product sign fix.
module mult_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/mult_sequencer.sv
// Radix-2 shift-add multiplier: WIDTH RUN steps on magnitudes, one FIX cycle applies the sign.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  mult_sequencer_if.slave  bus
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 sign_q, sign_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH:0]       step_sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic                 busy;

  // 0x80..0 negates to itself; read unsigned it is the correct magnitude 2^(WIDTH-1).
  mult_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
    .a   (bus.op_a),
    .neg (bus.mult_sign & bus.op_a[WIDTH-1]),
    .y   (abs_a)
  );

  mult_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
    .a   (bus.op_b),
    .neg (bus.mult_sign & bus.op_b[WIDTH-1]),
    .y   (abs_b)
  );

  mult_abs_neg #(.WIDTH(2*WIDTH)) u_fix (
    .a   (acc_q),
    .neg (sign_q),
    .y   (prod_fix)
  );

  // Carry out of the upper-half add becomes the new MSB after the right shift.
  assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{mplier_q[0]}}};
  assign acc_step = {step_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_mult) begin
          mcand_d  = abs_a;
          mplier_d = abs_b;
          sign_d   = bus.mult_sign & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        {hi_d, lo_d} = prod_fix;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Operand latches are only consumed after a fresh IDLE load, so they need no reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    sign_q   <= sign_d;
  end

  assign busy        = (state_q != IDLE);
  assign bus.busy    = busy;
  assign bus.stall_d = busy & (bus.start_mult | bus.mfhi_d | bus.mflo_d);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: directed multiplies, hazard stalls and reset abort.
module tb_mult_sequencer;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] exp_q[$];
  int          acc_time_q[$];

  mult_sequencer_if #(.WIDTH(W)) bus ();

  mult_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp, input bit push);
    int n;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.mult_sign  = s;
    bus.start_mult = 1'b1;
    if (push) exp_q.push_back(exp);
    n = 0;
    while (bus.busy && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("issue_timeout", 64'(n), 64'(0));
    step();
    bus.start_mult = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(n), 64'(0));
  endtask

  // Monitor: records acceptance edges and checks every done pulse against the scoreboard.
  initial begin
    logic [63:0] e;
    int          t;
    forever begin
      @(negedge clk);
      if (!reset) begin
        acc_time_q.delete();
      end else if (bus.start_mult && !bus.busy) begin
        acc_time_q.push_back(cyc + 1);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d required no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          check("product_hi", 64'(bus.hi), 64'(e[63:32]));
          check("product_lo", 64'(bus.lo), 64'(e[31:0]));
          if (acc_time_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL latency: got done with no accepted start, required an accept");
          end else begin
            t = acc_time_q.pop_front();
            check("latency", 64'(cyc - t), 64'(LATENCY));
          end
        end
      end
    end
  end

  initial begin
    int          k;
    logic [63:0] prev, exp_a, exp_b;

    reset          = 1'b0;
    bus.start_mult = 1'b0;
    bus.mult_sign  = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.mfhi_d     = 1'b1;
    bus.mflo_d     = 1'b1;
    repeat (3) step();
    check("reset_hi",    64'(bus.hi),      64'(0));
    check("reset_lo",    64'(bus.lo),      64'(0));
    check("reset_busy",  64'(bus.busy),    64'(0));
    check("reset_done",  64'(bus.done),    64'(0));
    check("reset_stall", 64'(bus.stall_d), 64'(0));
    reset      = 1'b1;
    bus.mfhi_d = 1'b0;
    bus.mflo_d = 1'b0;
    step();

    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 1'b1);
    wait_idle();
    issue(32'hFFFFFFFF, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFF9, 1'b1);
    wait_idle();
    issue(32'hFFFFFFFF, 32'h00000007, 1'b0, 64'h00000006_FFFFFFF9, 1'b1);
    wait_idle();
    issue(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 1'b1);
    wait_idle();
    issue(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000, 1'b1);
    wait_idle();
    issue(32'h00000000, 32'h00012345, 1'b1, 64'h00000000_00000000, 1'b1);
    wait_idle();
    issue(32'h00000003, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 1'b1);
    wait_idle();
    prev = 64'hFFFFFFFF_FFFFFFF1;

    // Hazard: mflo at cycle 5, second start at cycle 10 held until IDLE.
    exp_a = 64'h00000001_23456780;
    exp_b = 64'hFFFFFFFF_FFFFFFFA;
    issue(32'h12345678, 32'h00000010, 1'b0, exp_a, 1'b1);
    k = 0;
    while (bus.busy && k < 100) begin
      step();
      k++;
      if (k == 5) bus.mflo_d = 1'b1;
      if (k == 10) begin
        bus.op_a       = 32'hFFFFFFFE;
        bus.op_b       = 32'h00000003;
        bus.mult_sign  = 1'b1;
        bus.start_mult = 1'b1;
        exp_q.push_back(exp_b);
      end
      #1;
      if (bus.busy) begin
        check("hazard_stall", 64'(bus.stall_d), 64'(k >= 5));
        check("hold_lo", 64'(bus.lo), 64'(prev[31:0]));
      end
    end
    check("busy_cycles", 64'(k), 64'(LATENCY));
    check("idle_stall",  64'(bus.stall_d), 64'(0));
    check("mflo_new_lo", 64'(bus.lo), 64'(exp_a[31:0]));
    check("mfhi_new_hi", 64'(bus.hi), 64'(exp_a[63:32]));
    step();
    bus.start_mult = 1'b0;
    bus.mflo_d     = 1'b0;
    check("second_accepted", 64'(bus.busy), 64'(1));
    wait_idle();

    // Reset abort during RUN cycle 12.
    issue(32'h00001234, 32'h00005678, 1'b0, 64'h0, 1'b0);
    repeat (12) step();
    check("abort_in_run", 64'(bus.busy), 64'(1));
    reset = 1'b0;
    step();
    #1;
    check("abort_busy",  64'(bus.busy),    64'(0));
    check("abort_hi",    64'(bus.hi),      64'(0));
    check("abort_lo",    64'(bus.lo),      64'(0));
    check("abort_done",  64'(bus.done),    64'(0));
    check("abort_stall", 64'(bus.stall_d), 64'(0));
    reset = 1'b1;
    step();
    issue(32'h00000003, 32'h00000005, 1'b0, 64'h00000000_0000000F, 1'b1);
    wait_idle();

    repeat (3) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; HI and LO are each WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-004 The block SHALL have port start_mult, input, 1 bit: the decode stage requests a multiply.
REQ-005 The block SHALL have port mult_sign, input, 1 bit: 1 = signed (mult), 0 = unsigned (multu); sampled with start_mult.
REQ-006 The block SHALL have ports op_a and op_b, input, WIDTH bits each: the multiplicand and multiplier, sampled with start_mult.
REQ-007 The block SHALL have ports mfhi_d and mflo_d, input, 1 bit each: the decode stage is reading HI or LO.
REQ-008 The block SHALL have ports hi and lo, output, WIDTH bits each: the architectural product registers.
REQ-009 The block SHALL have port busy, output, 1 bit: a multiply is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse when hi/lo take a new product.
REQ-011 The block SHALL have port stall_d, output, 1 bit: freeze the fetch and decode stages.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and FIX.
REQ-013 In IDLE with start_mult=1, the block SHALL latch |op_a| and |op_b| (raw values if mult_sign=0), latch the result sign (sign_a XOR sign_b, forced 0 when unsigned), clear the 2*WIDTH accumulator and the counter, and move to RUN.
REQ-014 Each RUN cycle SHALL run one radix-2 shift-add step: add the multiplicand to the upper half if the multiplier LSB is 1, then shift the combined value right by one, with the carry kept.
REQ-015 The counter SHALL run 0..WIDTH-1; when count=WIDTH-1, the block SHALL move to FIX (exactly WIDTH RUN cycles).
REQ-016 In FIX, the block SHALL write {hi,lo} = the accumulator, two's-complement negated over 2*WIDTH bits if the result sign is 1; it SHALL assert done for the next cycle and return to IDLE.
REQ-017 Latency: with start sampled at edge E0, hi/lo SHALL update at edge E0+WIDTH+1 (33 for WIDTH=32).
REQ-018 busy SHALL be 1 exactly when state != IDLE.
REQ-019 stall_d SHALL equal busy AND (start_mult OR mfhi_d OR mflo_d); it is combinational and is 0 in IDLE.
REQ-020 A start_mult while busy SHALL NOT be accepted; it is stalled and accepted in the first IDLE cycle.
REQ-021 In the IDLE cycle after FIX, mfhi_d/mflo_d SHALL see the new hi/lo with no stall.
REQ-022 hi/lo SHALL hold their value except in FIX.
REQ-023 Boundary: signed 0x80000000 x 0x80000000 SHALL give 0x40000000_00000000; the magnitude 2^(WIDTH-1) is handled as unsigned.
REQ-024 A zero operand SHALL still take the full latency; there is no early termination.

Reset
REQ-025 While reset=0 at a clock edge: state=IDLE, counter=0, accumulator=0, hi=0, lo=0, done=0.
REQ-026 Resulting outputs: busy=0, stall_d=0.
REQ-027 A reset during RUN or FIX SHALL abort the multiply with no hi/lo update and no done pulse.
REQ-028 The first start_mult after reset is released SHALL be accepted normally.

Structure
REQ-029 The shared package SHALL hold the FSM state enum (IDLE, RUN, FIX) and the default WIDTH constant.
REQ-030 One sub-module SHALL exist, mult_abs_neg: a combinational conditional two's-complement negate, parameterised by width, used for operand magnitudes and the product sign fix.
REQ-031 The shift-add datapath, counter and FSM SHALL sit in mult_sequencer; hi/lo SHALL be the only architectural registers.

Verification
REQ-032 Unsigned: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, sign=0 -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after start.
REQ-033 Signed: op_a=0xFFFFFFFF (-1), op_b=0x00000007, sign=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF9; same operands with sign=0 -> hi=0x00000006, lo=0xFFFFFFF9.
REQ-034 Signed min: 0x80000000 x 0x80000000, sign=1 -> hi=0x40000000, lo=0x00000000.
REQ-035 Hazard: mflo_d=1 at cycle 5 after start -> stall_d=1 through the FIX cycle, then 0; the mflo read sees the new lo. A second start_mult at cycle 10 -> stalled, accepted in the first IDLE cycle, second product correct.
REQ-036 Reset: reset=0 at RUN cycle 12 -> next cycle busy=0, hi=lo=0, no done pulse; a new 3 x 5 multiply then gives lo=15, hi=0.
